// File: rtl/decode_queue_if.sv
// Instruction-in / decoded-bundle-out handshake of the branch-decode stage.
// The slave modport is the decode_queue view; master is the surrounding pipeline.
interface decode_queue_if #(
    parameter int INS_W = 16,
    parameter int REG_W = 4
);
    logic             ins_valid;
    logic             ins_ready;
    logic [INS_W-1:0] ins;
    logic             out_valid;
    logic             out_ready;
    logic             is_br;
    logic             read_a;
    logic             imm_a;
    logic [REG_W:0]   arg_a;
    logic             read_b;
    logic [REG_W-1:0] src_b;
    logic             set_pc;
    logic             add_pc;
    logic [2:0]       cmp_b;
    logic             target_en;
    logic [INS_W-1:0] target;

    modport slave (
        input  ins_valid, ins, out_ready,
        output ins_ready, out_valid, is_br, read_a, imm_a, arg_a, read_b,
               src_b, set_pc, add_pc, cmp_b, target_en, target
    );

    modport master (
        output ins_valid, ins, out_ready,
        input  ins_ready, out_valid, is_br, read_a, imm_a, arg_a, read_b,
               src_b, set_pc, add_pc, cmp_b, target_en, target
    );
endinterface

// File: rtl/decode_queue.sv
// Branch-decode stage: two-word sequencer (JMPIMM + target word) feeding a
// DEPTH-entry in-order queue of decoded bundles.
`ifndef OPCODE
`define OPCODE 15:12
`endif
`ifndef OPCODE_JMP
`define OPCODE_JMP 4'h1
`endif
`ifndef OPCODE_JMPIMM
`define OPCODE_JMPIMM 4'h2
`endif
`ifndef OPCODE_B
`define OPCODE_B 4'h3
`endif
`ifndef OPCODE_BN
`define OPCODE_BN 4'h4
`endif

module decode_queue #(
    parameter int INS_W = 16,
    parameter int REG_W = 4,
    parameter int DEPTH = 2
) (
    input  logic          cpu_clk,
    input  logic          cpu_rst_n,
    input  logic          flush,
    decode_queue_if.slave q
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    function automatic logic [INS_W-1:0] opcode_mask_f();
        logic [INS_W-1:0] m;
        m = {INS_W{1'b0}};
        m[`OPCODE] = ~m[`OPCODE];
        return m;
    endfunction

    function automatic logic [INS_W-1:0] field_mask_f();
        logic [INS_W-1:0] m;
        m = {INS_W{1'b0}};
        for (int i = 0; i < INS_W; i++) m[i] = (i < 2 * REG_W + 2);
        return m;
    endfunction

    // REG_A, REG_B and IMM together occupy ins[2*REG_W+1:0]; the opcode must sit above them.
    if (((opcode_mask_f() & field_mask_f()) != {INS_W{1'b0}}) ||
        (DEPTH < 1) || (2 * REG_W + 2 > INS_W)) begin : g_bad_cfg
        $error("decode_queue: operand fields overlap the opcode field or DEPTH < 1");
    end

    typedef struct packed {
        logic             is_br;
        logic             read_a;
        logic             imm_a;
        logic [REG_W:0]   arg_a;
        logic             read_b;
        logic [REG_W-1:0] src_b;
        logic             set_pc;
        logic             add_pc;
        logic [2:0]       cmp_b;
        logic             target_en;
        logic [INS_W-1:0] target;
    } entry_t;

    localparam entry_t ZERO_ENTRY = entry_t'({$bits(entry_t){1'b0}});

    typedef enum logic [0:0] {S_OP = 1'b0, S_EXT = 1'b1} state_t;

    state_t          state_r, state_nx_s;
    entry_t          mem_r [DEPTH];
    logic [PW-1:0]   wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]   count_r;
    entry_t          dec_s, push_entry_s, head_s;
    logic            ins_ready_s, out_valid_s, accept_s, pop_s, push_s, is_jmpimm_s;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? {PW{1'b0}} : p + PW'(1);
    endfunction

    assign ins_ready_s = !flush && (count_r != DEPTH_C);
    assign out_valid_s = !flush && (count_r != {CW{1'b0}});
    assign accept_s    = q.ins_valid && ins_ready_s;
    assign pop_s       = out_valid_s && q.out_ready;
    assign is_jmpimm_s = (q.ins[`OPCODE] == `OPCODE_JMPIMM);

    // Single-word decode of the opcode word; unknown opcodes become a zero bundle.
    always_comb begin
        dec_s = ZERO_ENTRY;
        case (q.ins[`OPCODE])
            `OPCODE_JMP: begin
                dec_s.is_br  = 1'b1;
                dec_s.read_a = 1'b1;
                dec_s.arg_a  = {1'b0, q.ins[REG_W+1:2]};
                dec_s.read_b = 1'b1;
                dec_s.src_b  = q.ins[2*REG_W+1:REG_W+2];
                dec_s.set_pc = 1'b1;
            end
            `OPCODE_B: begin
                dec_s.is_br  = 1'b1;
                dec_s.read_a = 1'b1;
                dec_s.arg_a  = {1'b0, q.ins[REG_W+1:2]};
                dec_s.read_b = 1'b1;
                dec_s.src_b  = q.ins[2*REG_W+1:REG_W+2];
                dec_s.add_pc = 1'b1;
                dec_s.cmp_b  = {q.ins[1:0], 1'b1};
            end
            `OPCODE_BN: begin
                dec_s.is_br  = 1'b1;
                dec_s.imm_a  = 1'b1;
                dec_s.arg_a  = q.ins[REG_W+1:1];
                dec_s.read_b = 1'b1;
                dec_s.src_b  = q.ins[2*REG_W+1:REG_W+2];
                dec_s.add_pc = 1'b1;
                dec_s.cmp_b  = {1'b0, q.ins[0], 1'b1};
            end
            default: dec_s = ZERO_ENTRY;
        endcase
    end

    // Sequencer: JMPIMM defers its push until the target word arrives.
    always_comb begin
        state_nx_s   = state_r;
        push_s       = 1'b0;
        push_entry_s = dec_s;
        case (state_r)
            S_OP: begin
                if (accept_s && is_jmpimm_s) begin
                    state_nx_s = S_EXT;
                end else if (accept_s) begin
                    push_s = 1'b1;
                end else begin
                    push_s = 1'b0;
                end
            end
            S_EXT: begin
                if (accept_s) begin
                    push_s                 = 1'b1;
                    push_entry_s           = ZERO_ENTRY;
                    push_entry_s.is_br     = 1'b1;
                    push_entry_s.set_pc    = 1'b1;
                    push_entry_s.target_en = 1'b1;
                    push_entry_s.target    = q.ins;
                    state_nx_s             = S_OP;
                end else begin
                    state_nx_s = S_EXT;
                end
            end
            default: state_nx_s = S_OP;
        endcase
    end

    // Sequencer state register; flush drops any half-received JMPIMM.
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_r <= S_OP;
        end else if (flush) begin
            state_r <= S_OP;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Circular entry store with occupancy count.
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            count_r  <= {CW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            for (int i = 0; i < DEPTH; i++) mem_r[i] <= ZERO_ENTRY;
        end else if (flush) begin
            count_r  <= {CW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= push_entry_s;
                wr_ptr_r        <= next_ptr(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Head bundle is presented only while valid, otherwise all zero.
    always_comb begin
        if (out_valid_s) begin
            head_s = mem_r[rd_ptr_r];
        end else begin
            head_s = ZERO_ENTRY;
        end
    end

    assign q.ins_ready = ins_ready_s;
    assign q.out_valid = out_valid_s;
    assign q.is_br     = head_s.is_br;
    assign q.read_a    = head_s.read_a;
    assign q.imm_a     = head_s.imm_a;
    assign q.arg_a     = head_s.arg_a;
    assign q.read_b    = head_s.read_b;
    assign q.src_b     = head_s.src_b;
    assign q.set_pc    = head_s.set_pc;
    assign q.add_pc    = head_s.add_pc;
    assign q.cmp_b     = head_s.cmp_b;
    assign q.target_en = head_s.target_en;
    assign q.target    = head_s.target;
endmodule

// File: tb/tb_decode_queue.sv
// Randomised + directed scoreboard bench for decode_queue.
`ifndef OPCODE
`define OPCODE 15:12
`endif
`ifndef OPCODE_JMP
`define OPCODE_JMP 4'h1
`endif
`ifndef OPCODE_JMPIMM
`define OPCODE_JMPIMM 4'h2
`endif
`ifndef OPCODE_B
`define OPCODE_B 4'h3
`endif
`ifndef OPCODE_BN
`define OPCODE_BN 4'h4
`endif

module tb_decode_queue;
    localparam int INS_W = 16;
    localparam int REG_W = 4;
    localparam int DEPTH = 2;
    localparam int BW    = 3 + (REG_W + 1) + 1 + REG_W + 2 + 3 + 1 + INS_W;

    localparam logic [3:0] OP_JMP    = `OPCODE_JMP;
    localparam logic [3:0] OP_JMPIMM = `OPCODE_JMPIMM;
    localparam logic [3:0] OP_B      = `OPCODE_B;
    localparam logic [3:0] OP_BN     = `OPCODE_BN;

    logic cpu_clk   = 1'b0;
    logic cpu_rst_n = 1'b0;
    logic flush     = 1'b0;

    decode_queue_if #(.INS_W(INS_W), .REG_W(REG_W)) q ();

    decode_queue #(.INS_W(INS_W), .REG_W(REG_W), .DEPTH(DEPTH)) dut (
        .cpu_clk   (cpu_clk),
        .cpu_rst_n (cpu_rst_n),
        .flush     (flush),
        .q         (q)
    );

    always #5 cpu_clk = ~cpu_clk;

    int              n_cmp = 0;
    int              n_bad = 0;
    logic [BW-1:0]   sbq[$];
    int              m_cnt = 0;
    bit              m_ext = 1'b0;
    logic [BW-1:0]   dut_b;

    assign dut_b = {q.is_br, q.read_a, q.imm_a, q.arg_a, q.read_b, q.src_b,
                    q.set_pc, q.add_pc, q.cmp_b, q.target_en, q.target};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [BW-1:0] mk(bit br, bit ra, bit ia, int aa, bit rb, int sb,
                                         bit sp, bit ap, int cb, bit te, int tg);
        return {br, ra, ia, (REG_W+1)'(aa), rb, REG_W'(sb), sp, ap, 3'(cb), te, INS_W'(tg)};
    endfunction

    // Expected bundle for a single opcode word, from the field definitions.
    function automatic logic [BW-1:0] model_entry(logic [INS_W-1:0] w);
        int wi  = int'(w);
        int ra  = (wi >> 2) % (1 << REG_W);
        int rb  = (wi >> (REG_W + 2)) % (1 << REG_W);
        int imm = (wi >> 1) % (1 << (REG_W + 1));
        int fn  = wi % 4;
        logic [3:0] op = w[`OPCODE];
        if (op == OP_JMP) return mk(1, 1, 0, ra, 1, rb, 1, 0, 0, 0, 0);
        if (op == OP_B)   return mk(1, 1, 0, ra, 1, rb, 0, 1, fn * 2 + 1, 0, 0);
        if (op == OP_BN)  return mk(1, 0, 1, imm, 1, rb, 0, 1, (fn % 2) * 2 + 1, 0, 0);
        return '0;
    endfunction

    function automatic logic [INS_W-1:0] mkw(logic [3:0] op, int rb, int low6);
        logic [INS_W-1:0] w;
        w = INS_W'((rb << 6) | low6);
        w[`OPCODE] = op;
        return w;
    endfunction

    // Reference model: queue occupancy and expected entries, updated at each edge.
    initial forever begin
        bit pop, push, acc;
        @(posedge cpu_clk or negedge cpu_rst_n);
        if (!cpu_rst_n || flush) begin
            m_cnt = 0;
            m_ext = 1'b0;
            sbq.delete();
        end else begin
            pop  = (m_cnt != 0) && q.out_ready;
            acc  = q.ins_valid && (m_cnt != DEPTH);
            push = 1'b0;
            if (acc && m_ext) begin
                sbq.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 1, int'(q.ins)));
                m_ext = 1'b0;
                push  = 1'b1;
            end else if (acc && q.ins[`OPCODE] == OP_JMPIMM) begin
                m_ext = 1'b1;
            end else if (acc) begin
                sbq.push_back(model_entry(q.ins));
                push = 1'b1;
            end
            m_cnt = m_cnt + int'(push) - int'(pop);
        end
    end

    // Monitor: compares handshake and head bundle mid-cycle, pops on consumption.
    initial forever begin
        bit ev;
        @(negedge cpu_clk);
        if (cpu_rst_n) begin
            ev = (m_cnt != 0) && !flush;
            check("ins_ready", 64'(q.ins_ready), 64'(!flush && m_cnt != DEPTH));
            check("out_valid", 64'(q.out_valid), 64'(ev));
            if (ev && sbq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL head: scoreboard empty while entry expected at %0t", $time);
            end else if (ev) begin
                check("head", 64'(dut_b), 64'(sbq[0]));
                if (q.out_ready) void'(sbq.pop_front());
            end else begin
                check("idle_bundle", 64'(dut_b), 64'd0);
            end
        end
    end

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    // Present a word and hold it until the DUT accepts it (bounded).
    task automatic send(input logic [INS_W-1:0] w);
        int n = 0;
        bit acc = 1'b0;
        q.ins_valid = 1'b1;
        q.ins       = w;
        while (!acc && n < 50) begin
            @(negedge cpu_clk);
            acc = q.ins_ready;
            tick();
            n++;
        end
        q.ins_valid = 1'b0;
        n_cmp++;
        if (!acc) begin
            n_bad++;
            $display("FAIL accept_timeout: word %h not accepted within 50 cycles", w);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] ops [6];
        logic [INS_W-1:0] w;
        ops = '{4'h0, OP_JMP, OP_JMPIMM, OP_B, OP_BN, 4'hF};
        q.ins_valid = 1'b0;
        q.ins       = '0;
        q.out_ready = 1'b0;
        #12 cpu_rst_n = 1'b1;
        @(negedge cpu_clk);
        check("rst_ins_ready", 64'(q.ins_ready), 64'd1);
        check("rst_out_valid", 64'(q.out_valid), 64'd0);
        check("rst_bundle", 64'(dut_b), 64'd0);
        tick();

        // B r3,r5 fn=2'b10
        q.out_ready = 1'b1;
        send(mkw(OP_B, 5, (3 << 2) | 2));
        @(negedge cpu_clk);
        check("t1_valid", 64'(q.out_valid), 64'd1);
        check("t1_arg_a", 64'(q.arg_a), 64'd3);
        check("t1_src_b", 64'(q.src_b), 64'd5);
        check("t1_add_pc", 64'(q.add_pc), 64'd1);
        check("t1_cmp_b", 64'(q.cmp_b), 64'b101);
        tick();

        // BN IMM=10110, ins[0]=1
        send(mkw(OP_BN, 7, 6'b101101));
        @(negedge cpu_clk);
        check("t2_imm_a", 64'(q.imm_a), 64'd1);
        check("t2_read_a", 64'(q.read_a), 64'd0);
        check("t2_arg_a", 64'(q.arg_a), 64'b10110);
        check("t2_cmp_b", 64'(q.cmp_b), 64'b011);
        repeat (3) tick();

        // JMPIMM, three idle cycles, then the target word
        send(mkw(OP_JMPIMM, 0, 0));
        for (int i = 0; i < 3; i++) begin
            @(negedge cpu_clk);
            check("t3_gap_valid", 64'(q.out_valid), 64'd0);
            tick();
        end
        send(16'hBEEF);
        @(negedge cpu_clk);
        check("t3_target", 64'(q.target), 64'hBEEF);
        check("t3_target_en", 64'(q.target_en), 64'd1);
        check("t3_set_pc", 64'(q.set_pc), 64'd1);
        repeat (3) tick();

        // Fill with the consumer stalled, then stream through
        q.out_ready = 1'b0;
        send(mkw(OP_JMP, 1, 2 << 2));
        send(mkw(OP_JMP, 3, 4 << 2));
        @(negedge cpu_clk);
        check("t4_full_ready", 64'(q.ins_ready), 64'd0);
        tick();
        q.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) send(mkw(OP_JMP, i + 5, i << 2));
        repeat (3) tick();

        // JMPIMM discarded by flush; following ALU word gives a zero bundle
        send(mkw(OP_JMPIMM, 0, 0));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge cpu_clk);
        check("t5_valid", 64'(q.out_valid), 64'd0);
        check("t5_ready", 64'(q.ins_ready), 64'd1);
        tick();
        send(16'h0ABC);
        @(negedge cpu_clk);
        check("t5_alu_valid", 64'(q.out_valid), 64'd1);
        check("t5_alu_is_br", 64'(q.is_br), 64'd0);
        check("t5_alu_bundle", 64'(dut_b), 64'd0);
        repeat (3) tick();

        // Async reset while holding an entry and waiting for a JMPIMM target
        q.out_ready = 1'b0;
        send(mkw(OP_JMP, 2, 1 << 2));
        send(mkw(OP_JMPIMM, 0, 0));
        #3 cpu_rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 64'(q.out_valid), 64'd0);
        check("t6_rst_bundle", 64'(dut_b), 64'd0);
        tick();
        cpu_rst_n = 1'b1;
        @(negedge cpu_clk);
        check("t6_rel_ready", 64'(q.ins_ready), 64'd1);
        check("t6_rel_valid", 64'(q.out_valid), 64'd0);
        check("t6_rel_bundle", 64'(dut_b), 64'd0);
        tick();
        q.out_ready = 1'b1;
        send(mkw(OP_B, 9, (6 << 2) | 1));
        repeat (3) tick();

        // Random traffic with occasional flushes
        for (int i = 0; i < 800; i++) begin
            w = INS_W'($urandom);
            w[`OPCODE] = ops[$urandom_range(0, 5)];
            q.ins       = w;
            q.ins_valid = ($urandom_range(0, 3) != 0);
            q.out_ready = ($urandom_range(0, 3) != 0);
            flush       = ($urandom_range(0, 39) == 0);
            tick();
        end
        q.ins_valid = 1'b0;
        flush       = 1'b0;
        q.out_ready = 1'b1;
        repeat (5) tick();
        check("drained", 64'(sbq.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
